// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared width default, FSM states, op-type encoding and divide-by-zero quotient for mult_div_unit
package mult_div_pkg;
  localparam int WIDTH_DEF = 32;
  localparam logic [WIDTH_DEF-1:0] DIV0_LO = '1;
  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;
  typedef enum logic {OP_MUL, OP_DIV} op_t;
endpackage

// File: rtl/mult_div_if.sv
// mult_div_if: controller-side bundle (mult/div start pulses, rs/rt operands) and unit-side results (done pulses, hi/lo, busy, div_by_zero)
interface mult_div_if import mult_div_pkg::*; #(parameter int WIDTH = WIDTH_DEF);
  logic             mult_start, div_start;
  logic [WIDTH-1:0] op_a, op_b;
  logic             mult_done, div_done;
  logic [WIDTH-1:0] hi_out, lo_out;
  logic             busy, div_by_zero;
  modport master (output mult_start, div_start, op_a, op_b,
                  input mult_done, div_done, hi_out, lo_out, busy, div_by_zero);
  modport slave (input mult_start, div_start, op_a, op_b,
                 output mult_done, div_done, hi_out, lo_out, busy, div_by_zero);
endinterface

// File: rtl/twos_abs.sv
// twos_abs: y_o = neg_i ? -x_i : x_i (abs when neg_i is tied to the sign), sign_o = msb of x_i
module twos_abs #(parameter int W = 32) (
  input  logic [W-1:0] x_i,
  input  logic         neg_i,
  output logic [W-1:0] y_o,
  output logic         sign_o
);
  assign y_o = neg_i ? -x_i : x_i;
  assign sign_o = x_i[W-1];
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: sequential signed MULT/DIV (shift-add / restoring, one bit per cycle); ports clk, reset (async active-low), bus (mult_div_if.slave)
module mult_div_unit import mult_div_pkg::*; #(parameter int WIDTH = WIDTH_DEF) (
  input logic       clk,
  input logic       reset,
  mult_div_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t             state_q, state_d;
  op_t                op_q, op_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   m_q, m_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] p_q, p_d, step, prod_fix;
  logic               neg_q, neg_d, rneg_q, rneg_d, dbz_q, dbz_d;
  logic [WIDTH-1:0]   mag_a, mag_b, quo_fix, rem_fix;
  logic [WIDTH:0]     sum, diff;
  logic               sa, sb;
  logic [2:0]         unused_sign;
  twos_abs #(.W(WIDTH)) abs_a (.x_i(bus.op_a), .neg_i(bus.op_a[WIDTH-1]), .y_o(mag_a), .sign_o(sa));
  twos_abs #(.W(WIDTH)) abs_b (.x_i(bus.op_b), .neg_i(bus.op_b[WIDTH-1]), .y_o(mag_b), .sign_o(sb));
  twos_abs #(.W(2*WIDTH)) fix_p (.x_i(step), .neg_i(neg_q), .y_o(prod_fix), .sign_o(unused_sign[0]));
  twos_abs #(.W(WIDTH)) fix_q (.x_i(step[WIDTH-1:0]), .neg_i(neg_q), .y_o(quo_fix), .sign_o(unused_sign[1]));
  twos_abs #(.W(WIDTH)) fix_r (.x_i(step[2*WIDTH-1:WIDTH]), .neg_i(rneg_q), .y_o(rem_fix), .sign_o(unused_sign[2]));
  assign sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, p_q[0] ? m_q : '0};
  assign diff = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]} - {1'b0, m_q};
  assign step = (state_q == MUL_RUN) ? {sum, p_q[WIDTH-1:1]}
              : {diff[WIDTH] ? p_q[2*WIDTH-2:WIDTH-1] : diff[WIDTH-1:0], p_q[WIDTH-2:0], ~diff[WIDTH]};
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    cnt_d = cnt_q;
    m_d = m_q;
    p_d = p_q;
    hi_d = hi_q;
    lo_d = lo_q;
    neg_d = neg_q;
    rneg_d = rneg_q;
    dbz_d = dbz_q;
    case (state_q)
      IDLE: if (bus.mult_start || bus.div_start) begin
        op_d = bus.mult_start ? OP_MUL : OP_DIV;
        m_d = bus.mult_start ? mag_a : mag_b;
        p_d = {{WIDTH{1'b0}}, bus.mult_start ? mag_b : mag_a};
        neg_d = sa ^ sb;
        rneg_d = sa;
        cnt_d = CW'(WIDTH);
        dbz_d = 1'b0;
        state_d = bus.mult_start ? MUL_RUN : DIV_RUN;
        if (!bus.mult_start && bus.op_b == '0) begin
          state_d = DONE;
          hi_d = bus.op_a;
          lo_d = DIV0_LO;
          dbz_d = 1'b1;
        end
      end
      MUL_RUN, DIV_RUN: begin
        p_d = step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          hi_d = (state_q == MUL_RUN) ? prod_fix[2*WIDTH-1:WIDTH] : rem_fix;
          lo_d = (state_q == MUL_RUN) ? prod_fix[WIDTH-1:0] : quo_fix;
        end
      end
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q <= OP_MUL;
      cnt_q <= '0;
      m_q <= '0;
      p_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      neg_q <= 1'b0;
      rneg_q <= 1'b0;
      dbz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
      m_q <= m_d;
      p_q <= p_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      neg_q <= neg_d;
      rneg_q <= rneg_d;
      dbz_q <= dbz_d;
    end
  end
  assign bus.mult_done = state_q == DONE && op_q == OP_MUL;
  assign bus.div_done = state_q == DONE && op_q == OP_DIV;
  assign bus.busy = state_q != IDLE;
  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;
  assign bus.div_by_zero = dbz_q;
endmodule
